ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave that services the core's instruction fetches and data loads/stores issued by the master glue logic. It sits directly downstream of the master on the AHB bus and drives the `hr_data`/`hready`/`hresp` signals back to it. The block holds a word-organised SRAM with byte-lane writes and inserts a configurable number of wait states per transfer. Out-of-range and misaligned accesses get a standard two-cycle ERROR response.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states inserted per transfer, 0..7.
- `WPROT_LIMIT`, 32'h0000_1000: byte offset below which writes are protected (used only with `SRAM_WPROT_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `hsel` in 1: slave select from the address decoder.
- `haddr` in 32: byte address; only offset `haddr[23:0]` is decoded.
- `htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 000 byte, 001 halfword, 010 word; other values are illegal.
- `hprot` in 4: captured; only used for debug visibility.
- `hwdata` in 32: write data, valid in the data phase.
- `hr_data` out 32: read data.
- `hready` out 1: transfer done / slave ready; also serves as the bus HREADY input.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.

## Operation
- **Reset values:** state IDLE, `hready`=1, `hresp`=0, `hr_data`=0, all capture registers cleared.
- **Memory array:** not reset; its contents survive `reset`.
- **Address phase accept:** `hsel && htrans[1] && hready` sampled at a clock edge.
  - Captures `haddr[23:0]`, `hwrite`, `hsize`, `hprot`.
  - SEQ is treated the same as NONSEQ.
- **IDLE/BUSY with `hsel`, or `!hsel`:** no access. `hready`=1, `hresp`=0.
- **Error checks** at accept; an error is flagged if any of these hold:
  - offset ≥ 4*`DEPTH`,
  - halfword with `addr[0]`=1,
  - word with `addr[1:0]`≠0,
  - `hsize` > 010.
- **States:**
  - IDLE: the accept condition moves to WAIT, or to XFER if `WAIT_CYCLES`=0, or to ERR1 on an error.
  - WAIT: counts down the `WAIT_CYCLES` cycles with `hready`=0, then moves to XFER.
  - XFER: `hready`=1, `hresp`=0.
    - Read: `hr_data` = full aligned word at `offset[ADDR]:2` (little-endian). Sub-word extraction and sign extension are the master/core's job.
    - Write: commits `hwdata` to the byte lanes selected by `hsize`/`offset[1:0]` at the end of this cycle.
  - ERR1: `hready`=0, `hresp`=1. Goes to ERR2.
  - ERR2: `hready`=1, `hresp`=1. Nothing is written.
- **Leaving XFER or ERR2:** the accept condition is re-evaluated in the same cycle, so back-to-back transfers are supported. Without a new accept the block returns to IDLE.
- **`hr_data` hold:** keeps its value until the next successful read's XFER cycle. Writes and errors do not change it.

## Timing
- Address phase sampled at edge N.
- Data phase occupies cycles N+1 … N+1+`WAIT_CYCLES`; `hready` is high only in the last of these.
- Zero-wait (`WAIT_CYCLES`=0): data returns at N+1, and a new transfer can be accepted every cycle.
- Read-after-write to the same address returns the new data, because the write commits at the XFER edge, before the following read's XFER.
- An error costs exactly 2 data-phase cycles regardless of `WAIT_CYCLES`.
- Inputs sampled while `hready`=0 are ignored; the master must hold the address phase.
- `reset` asserted mid-transfer: the transfer is aborted, no write is committed, and the block is in IDLE with reset outputs on the next cycle.

## Configuration
- `SRAM_WPROT_EN` defined: writes with offset < `WPROT_LIMIT` (the instruction region) take the ERROR response and memory is unchanged. Reads there stay legal.
- Not defined: writes are legal across the whole array and the `WPROT_LIMIT` parameter is unused.

## Structure
- Shared package `ahb_pkg`:
  - `htrans` encodings (IDLE/BUSY/NONSEQ/SEQ),
  - `hsize` encodings,
  - OKAY/ERROR constants,
  - slave state enum `ahb_slv_state_t` {IDLE, WAIT, XFER, ERR1, ERR2}.
- Sub-module `ahb_sram_array`: `DEPTH`×32 storage, 4-bit byte write enable, asynchronous read from word index.
- Top level: FSM, wait counter, error decode, byte-enable generation.

## Test plan
- Reset then idle: `hready`=1, `hresp`=0, `hr_data`=0. Hold `htrans`=00 with `hsel`=1 for 5 cycles → no state change.
- Word write `0xDEADBEEF` at offset 0x2000 (`WAIT_CYCLES`=1), then word read → `hready` low 1 cycle each; read returns `0xDEADBEEF` at N+2.
- Byte write `0xAA` at 0x2001, then word read of 0x2000 → `0xDEADAAEF`. Halfword write `0x1234` at 0x2002 → `0x1234AAEF`.
- Misaligned word read at 0x2002, and read at offset 4*`DEPTH` → ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1). `hr_data` unchanged.
- `WAIT_CYCLES`=0 back-to-back NONSEQ reads of 0x2000 and 0x2004 → data returned on consecutive cycles with `hready` constantly 1.
- With `SRAM_WPROT_EN`: word write at 0x0010 → ERROR, and a read of 0x0010 returns the old value. Without the macro → write succeeds. Also assert `reset` during WAIT of a write → no commit.

Source files
------------

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings, response codes, slave state enum
//               and the byte-lane helper used by the SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    // Transfer type encodings (HTRANS)
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // Transfer size encodings (HSIZE); anything above WORD is illegal here
    localparam logic [2:0] c_HSIZE_BYTE = 3'b000;
    localparam logic [2:0] c_HSIZE_HALF = 3'b001;
    localparam logic [2:0] c_HSIZE_WORD = 3'b010;

    // Response encodings (HRESP)
    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    // Slave data-phase state
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_XFER = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_t;

    // Byte lanes touched by an aligned transfer of the given size/offset.
    // Only called for legal sizes; illegal sizes never reach the data phase.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                              input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            c_HSIZE_BYTE: lanes = 4'b0001 << off;
            c_HSIZE_HALF: lanes = off[1] ? 4'b1100 : 4'b0011;
            default:      lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_slave_if.sv
// ============================================================================
// Module      : ahb_sram_slave_if
// Description : AHB-Lite signal bundle between the master glue logic and the
//               SRAM slave, with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hr_data;
    logic        hready;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
        input  hr_data, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
        output hr_data, hready, hresp
    );
endinterface

`default_nettype wire

// File: rtl/ahb_sram_array.sv
// ============================================================================
// Module      : ahb_sram_array
// Description : DEPTH x 32 word storage with per-byte write enables and an
//               asynchronous read port. Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_array #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-lane write: only the enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite SRAM slave with configurable wait states, byte-lane
//               writes and a two-cycle ERROR response for out-of-range,
//               misaligned or illegal-size accesses.
//               Optional macro SRAM_WPROT_EN: writes below WPROT_LIMIT are
//               rejected with ERROR and leave memory untouched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] WPROT_LIMIT = 32'h0000_1000
) (
    input  logic            clk,
    input  logic            reset,
    ahb_sram_slave_if.slave bus
);

    localparam int unsigned c_AW         = $clog2(DEPTH);
    localparam logic [24:0] c_BYTE_LIMIT = 25'(DEPTH * 4);
    localparam logic [2:0]  c_WAIT       = 3'(WAIT_CYCLES);

    ahb_slv_state_t r_state;
    ahb_slv_state_t w_next_state;

    logic [2:0]  r_wait_cnt;
    logic [23:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [3:0]  r_prot;
    logic [31:0] r_hr_data;

    logic        w_accept;
    logic        w_err;
    logic        w_hready;
    logic        w_hresp;
    logic        w_rd_sel;
    logic [3:0]  w_we;
    logic [31:0] w_rd_word;
    logic        w_unused;

    // A transfer is accepted only while the slave itself signals ready
    assign w_accept = bus.hsel && bus.htrans[1] && w_hready;

    // Error decode on the live address phase
    always_comb begin
        w_err = 1'b0;
        if ({1'b0, bus.haddr[23:0]} >= c_BYTE_LIMIT) begin
            w_err = 1'b1;
        end
        case (bus.hsize)
            c_HSIZE_BYTE: begin
                w_err = w_err;
            end
            c_HSIZE_HALF: begin
                if (bus.haddr[0]) w_err = 1'b1;
            end
            c_HSIZE_WORD: begin
                if (bus.haddr[1:0] != 2'b00) w_err = 1'b1;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
`ifdef SRAM_WPROT_EN
        if (bus.hwrite && ({8'h00, bus.haddr[23:0]} < WPROT_LIMIT)) begin
            w_err = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; XFER and ERR2 re-evaluate accept for back-to-back
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_XFER, ST_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = ST_ERR1;
                    end else if (c_WAIT == 3'd0) begin
                        w_next_state = ST_XFER;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= 3'd1) w_next_state = ST_XFER;
            end
            ST_ERR1: begin
                w_next_state = ST_ERR2;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bus response outputs decoded from state
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = c_HRESP_OKAY;
        case (r_state)
            ST_WAIT: begin
                w_hready = 1'b0;
            end
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = c_HRESP_ERROR;
            end
            ST_ERR2: begin
                w_hresp  = c_HRESP_ERROR;
            end
            default: begin
                w_hready = 1'b1;
            end
        endcase
    end

    // Wait-state countdown, loaded on accept and decremented while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 3'd0;
        end else if (w_accept) begin
            r_wait_cnt <= c_WAIT;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

    // Address-phase capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= 24'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_prot  <= 4'd0;
        end else if (w_accept) begin
            r_addr  <= bus.haddr[23:0];
            r_write <= bus.hwrite;
            r_size  <= bus.hsize;
            r_prot  <= bus.hprot;
        end
    end

    // Read data is live from the array during a read XFER and held otherwise,
    // so a write committed on the previous edge is already visible.
    assign w_rd_sel = (r_state == ST_XFER) && !r_write;

    // Hold register for the last successfully read word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hr_data <= 32'd0;
        end else if (w_rd_sel) begin
            r_hr_data <= w_rd_word;
        end
    end

    // Reset during the XFER cycle also suppresses the commit
    assign w_we = ((r_state == ST_XFER) && r_write && !reset)
                  ? byte_lanes(r_size, r_addr[1:0]) : 4'b0000;

    ahb_sram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr[c_AW+1:2]),
        .i_wdata (bus.hwdata),
        .o_rdata (w_rd_word)
    );

    assign bus.hr_data = w_rd_sel ? w_rd_word : r_hr_data;
    assign bus.hready  = w_hready;
    assign bus.hresp   = w_hresp;

    // Bits kept for debug visibility or not decoded by this slave
    assign w_unused = ^{bus.haddr[31:24], r_prot, r_addr, WPROT_LIMIT};

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Self-checking bench for ahb_sram_slave: one instance with one
//               wait state (directed + random traffic) and one zero-wait
//               instance (pipelined back-to-back traffic).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int unsigned c_DEPTH  = 4096;
    localparam logic [31:0] c_WPROT  = 32'h0000_1000;
    localparam int          c_WAIT_A = 1;
`ifdef SRAM_WPROT_EN
    localparam bit          c_WPROT_ON = 1'b1;
`else
    localparam bit          c_WPROT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ahb_sram_slave_if bus_a ();
    ahb_sram_slave_if bus_b ();

    ahb_sram_slave #(
        .DEPTH       (c_DEPTH),
        .WAIT_CYCLES (c_WAIT_A),
        .WPROT_LIMIT (c_WPROT)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    ahb_sram_slave #(
        .DEPTH       (c_DEPTH),
        .WAIT_CYCLES (0),
        .WPROT_LIMIT (c_WPROT)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Reference model: word-indexed memories plus the expected held read word
    logic [31:0] m_mem_a [int unsigned];
    logic [31:0] m_mem_b [int unsigned];
    logic [31:0] m_last_a;
    bit          m_last_ok;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Error rule: out of range, not naturally aligned, illegal size, protected write
    function automatic bit model_err(input bit wr, input logic [31:0] addr, input logic [2:0] size);
        int unsigned off;
        off = {8'h00, addr[23:0]};
        if (off >= 4 * c_DEPTH) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if ((off % (32'd1 << size)) != 0) return 1'b1;
        if (c_WPROT_ON && wr && (off < c_WPROT)) return 1'b1;
        return 1'b0;
    endfunction

    // Little-endian byte merge of a sub-word write into a stored word
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] w;
        int          lane;
        w = old;
        for (int b = 0; b < (1 << size); b++) begin
            lane = int'(addr[1:0]) + b;
            w[lane*8 +: 8] = wdata[lane*8 +: 8];
        end
        return w;
    endfunction

    task automatic idle_a();
        bus_a.hsel   = 1'b0;
        bus_a.htrans = c_HTRANS_IDLE;
    endtask

    // One complete transfer on instance A, checked against the model
    task automatic txn_a(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rd_obs);
        bit          err;
        int          exp_cyc;
        int          cyc;
        logic        first_rdy;
        logic        first_resp;
        int unsigned widx;
        err     = model_err(wr, addr, size);
        exp_cyc = err ? 2 : c_WAIT_A + 1;
        widx    = {10'd0, addr[23:2]};
        @(negedge clk);
        bus_a.hsel   = 1'b1;
        bus_a.haddr  = addr;
        bus_a.htrans = ($urandom_range(0, 1) == 0) ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
        bus_a.hwrite = wr;
        bus_a.hsize  = size;
        bus_a.hprot  = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus_a.hwdata = wdata;
        first_rdy    = bus_a.hready;
        first_resp   = bus_a.hresp;
        cyc          = 1;
        if (bus_a.hready === 1'b0) begin
            // junk address phase while stalled must be ignored
            bus_a.hsel   = 1'b1;
            bus_a.htrans = c_HTRANS_NONSEQ;
            bus_a.haddr  = 32'h0000_2000 + {26'd0, 6'($urandom)};
            bus_a.hwrite = 1'b1;
            bus_a.hsize  = 3'($urandom_range(0, 7));
        end else begin
            idle_a();
        end
        while (bus_a.hready !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            idle_a();
            cyc++;
        end
        chk("cycles", 32'(cyc), 32'(exp_cyc));
        chk("first_hready", {31'd0, first_rdy}, {31'd0, (exp_cyc == 1)});
        chk("first_hresp", {31'd0, first_resp}, {31'd0, err});
        chk("last_hresp", {31'd0, bus_a.hresp}, {31'd0, err});
        if (!err && !wr) begin
            m_last_ok = m_mem_a.exists(widx);
            if (m_last_ok) m_last_a = m_mem_a[widx];
        end
        rd_obs = bus_a.hr_data;
        if (m_last_ok) chk("hr_data", rd_obs, m_last_a);
        if (!err && wr) begin
            m_mem_a[widx] = merge(m_mem_a.exists(widx) ? m_mem_a[widx] : 32'hxxxx_xxxx,
                                  addr, size, wdata);
        end
    endtask

    // Zero-wait pipelined sequence on instance B
    bit          b_wr   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] b_addr [7] = '{32'h2000, 32'h2004, 32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h2004};
    logic [31:0] b_wdat [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] old;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        int          sel;

        reset = 1'b1;
        idle_a();
        bus_a.haddr = 32'd0; bus_a.hwrite = 1'b0; bus_a.hsize = 3'd0;
        bus_a.hprot = 4'd0;  bus_a.hwdata = 32'd0;
        bus_b.hsel = 1'b0; bus_b.htrans = c_HTRANS_IDLE; bus_b.haddr = 32'd0;
        bus_b.hwrite = 1'b0; bus_b.hsize = 3'd0; bus_b.hprot = 4'd0; bus_b.hwdata = 32'd0;
        m_last_a  = 32'd0;
        m_last_ok = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_hready_a", {31'd0, bus_a.hready}, 32'd1);
        chk("rst_hresp_a", {31'd0, bus_a.hresp}, 32'd0);
        chk("rst_hrdata_a", bus_a.hr_data, 32'd0);
        chk("rst_hrdata_b", bus_b.hr_data, 32'd0);

        // Selected but IDLE/BUSY: no state change
        for (int i = 0; i < 5; i++) begin
            bus_a.hsel   = 1'b1;
            bus_a.htrans = (i % 2 == 0) ? c_HTRANS_IDLE : c_HTRANS_BUSY;
            bus_a.haddr  = 32'h0000_2000 + 32'(4 * i);
            bus_a.hwrite = 1'(i);
            @(negedge clk);
            chk("idle_hready", {31'd0, bus_a.hready}, 32'd1);
            chk("idle_hresp", {31'd0, bus_a.hresp}, 32'd0);
            chk("idle_hrdata", bus_a.hr_data, 32'd0);
        end
        idle_a();

        // Preload a small window so random reads have known data
        for (int i = 0; i < 16; i++) begin
            txn_a(1'b1, 32'h0000_2000 + 32'(4 * i), c_HSIZE_WORD, $urandom, d);
        end

        // Directed byte-lane behaviour
        txn_a(1'b1, 32'h0000_2000, c_HSIZE_WORD, 32'hDEAD_BEEF, d);
        txn_a(1'b0, 32'h0000_2000, c_HSIZE_WORD, 32'd0, d);
        chk("rd_deadbeef", d, 32'hDEAD_BEEF);
        txn_a(1'b1, 32'h0000_2001, c_HSIZE_BYTE, 32'h0000_AA00, d);
        txn_a(1'b0, 32'h0000_2000, c_HSIZE_WORD, 32'd0, d);
        chk("rd_byte_merge", d, 32'hDEAD_AAEF);
        txn_a(1'b1, 32'h0000_2002, c_HSIZE_HALF, 32'h1234_0000, d);
        txn_a(1'b0, 32'h0000_2000, c_HSIZE_WORD, 32'd0, d);
        chk("rd_half_merge", d, 32'h1234_AAEF);

        // Error responses keep the held read data
        txn_a(1'b0, 32'h0000_2002, c_HSIZE_WORD, 32'd0, d);
        chk("err_misalign_hold", d, 32'h1234_AAEF);
        txn_a(1'b0, 32'(4 * c_DEPTH), c_HSIZE_WORD, 32'd0, d);
        chk("err_range_hold", d, 32'h1234_AAEF);

        // Write protection of the instruction region
        txn_a(1'b0, 32'h0000_0010, c_HSIZE_WORD, 32'd0, old);
        txn_a(1'b1, 32'h0000_0010, c_HSIZE_WORD, 32'hCAFE_F00D, d);
        txn_a(1'b0, 32'h0000_0010, c_HSIZE_WORD, 32'd0, d);
        chk("wprot_read", d, c_WPROT_ON ? old : 32'hCAFE_F00D);

        // Reset during the wait state of a write: nothing committed
        txn_a(1'b0, 32'h0000_2008, c_HSIZE_WORD, 32'd0, d);
        @(negedge clk);
        bus_a.hsel = 1'b1; bus_a.htrans = c_HTRANS_NONSEQ; bus_a.haddr = 32'h0000_2008;
        bus_a.hwrite = 1'b1; bus_a.hsize = c_HSIZE_WORD;
        @(posedge clk);
        @(negedge clk);
        idle_a();
        bus_a.hwdata = 32'h5555_AAAA;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_hready", {31'd0, bus_a.hready}, 32'd1);
        chk("rstmid_hresp", {31'd0, bus_a.hresp}, 32'd0);
        chk("rstmid_hrdata", bus_a.hr_data, 32'd0);
        m_last_a  = 32'd0;
        m_last_ok = 1'b1;
        txn_a(1'b0, 32'h0000_2008, c_HSIZE_WORD, 32'd0, d);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            addr = 32'h0000_2000 + 32'($urandom_range(0, 63));
            if (sel == 7) addr = 32'(4 * c_DEPTH) + 32'($urandom_range(0, 255));
            if (sel == 8) begin
                addr = 32'h0000_0100 + 32'($urandom_range(0, 255));
                wr   = 1'b1;
            end
            if (sel == 9) addr = {8'($urandom), addr[23:0]};
            sel = $urandom_range(0, 9);
            if (sel < 3)      size = c_HSIZE_BYTE;
            else if (sel < 6) size = c_HSIZE_HALF;
            else if (sel < 9) size = c_HSIZE_WORD;
            else              size = 3'($urandom_range(3, 7));
            txn_a(wr, addr, size, $urandom, d);
        end

        // Zero-wait back-to-back transfers on instance B
        for (int i = 0; i < 7; i++) b_wdat[i] = $urandom;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b_hready", {31'd0, bus_b.hready}, 32'd1);
                chk("b_hresp", {31'd0, bus_b.hresp}, 32'd0);
                if (b_wr[i-1]) begin
                    m_mem_b[b_addr[i-1] >> 2] = b_wdat[i-1];
                end else begin
                    chk("b_rdata", bus_b.hr_data, m_mem_b[b_addr[i-1] >> 2]);
                end
                bus_b.hwdata = b_wdat[i-1];
            end
            if (i < 7) begin
                bus_b.hsel   = 1'b1;
                bus_b.htrans = (i == 0) ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
                bus_b.haddr  = b_addr[i];
                bus_b.hwrite = b_wr[i];
                bus_b.hsize  = c_HSIZE_WORD;
            end else begin
                bus_b.hsel   = 1'b0;
                bus_b.htrans = c_HTRANS_IDLE;
            end
        end
        @(negedge clk);
        chk("b_idle_hready", {31'd0, bus_b.hready}, 32'd1);
        chk("b_hold", bus_b.hr_data, m_mem_b[32'h2004 >> 2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
